osd_regaccess_responder: RTL and testbench
==========================================

// Module: osd_regaccess_responder
// PURPOSE
//  Debug-ring endpoint that answers register-access request packets: accepts one
//  request from the router's local_out side, runs one access on a local register
//  bus, then returns the response packet into the router's local_in side. One
//  transaction in flight. It serves every debug module attached to a ring port.
// PARAMETERS
//  ACCESS_TIMEOUT  0  cycles to wait for reg_ack/reg_err; 0 = wait forever
// PORTS
//  clk         in   1   clock
//  rst         in   1   synchronous reset, active high
//  id          in   16  own ring address, used as src of responses
//  in_data     in   16  request word from router
//  in_valid    in   1   in_data valid
//  in_first    in   1   first word of packet
//  in_last     in   1   last word of packet
//  in_ready    out  1   word accepted when in_valid & in_ready
//  out_data    out  16  response word to router
//  out_valid   out  1   out_data valid
//  out_first   out  1   first word of response
//  out_last    out  1   last word of response
//  out_ready   in   1   router accepts when out_valid & out_ready
//  reg_request out  1   access request, held until reg_ack, reg_err or timeout
//  reg_write   out  1   1 = write, 0 = read; stable while reg_request
//  reg_addr    out  16  register address; stable while reg_request
//  reg_wdata   out  16  write data; stable while reg_request
//  reg_ack     in   1   access done OK; reg_rdata valid same cycle
//  reg_err     in   1   access failed; wins if asserted together with reg_ack
//  reg_rdata   in   16  read data
// BEHAVIOUR
//  Reset: all outputs 0, FSM -> RX_DEST, timeout counter 0.
//  Packet: w0 dest, w1 src, w2 flags, w3 addr, w4 wdata (write only).
//   flags[15:14] type (2'b00 = REG), flags[13:10] subtype:
//   req 0000 READ16, 0001 WRITE16; resp 1000 READ_OK, 1001 READ_ERR,
//   1010 WRITE_OK, 1011 WRITE_ERR; flags[9:0] = 0 in responses.
//  States: RX_DEST, RX_SRC, RX_FLAGS, RX_ADDR, RX_DATA, RX_DRAIN, ACCESS,
//   TX_DEST, TX_SRC, TX_FLAGS, TX_DATA.
//  in_ready = 1 only in RX_* states; out_valid = 1 only in TX_* states.
//  RX_DEST takes only in_first words; others discarded. w0 is not checked.
//  Captured src becomes response dest.
//  Any word with in_first in RX_SRC..RX_DRAIN aborts the current packet and
//   counts as w0 of a new one (same cycle, no response for the aborted one).
//  in_last before w3 accepted -> discard silently, back to RX_DEST.
//  type != REG -> RX_DRAIN, discard silently until in_last.
//  Unknown subtype, READ16 not ending at w3, or WRITE16 not ending at w4 ->
//   drain to in_last, then send READ_ERR (READ16 or unknown) / WRITE_ERR;
//   no bus access.
//  Valid request: reg_request rises the cycle after last word is accepted.
//  In ACCESS, the first cycle with reg_ack|reg_err drops reg_request next cycle
//   and captures rdata and status. Timeout counter counts reg_request cycles;
//   reaching ACCESS_TIMEOUT (if nonzero) = reg_err.
//  TX: out_valid rises the cycle after ACCESS ends. Words: dest, id, flags,
//   then rdata for READ_OK only. out_first on word 0, out_last on final word.
//   Each word holds until out_ready; the next word follows the cycle after.
//  After the final handshake -> RX_DEST; in_ready = 1 next cycle.
//  Backpressure: no word is dropped or duplicated when out_ready stays low
//   for any length of time.
//  rst mid-operation: abandon at once, outputs 0 next cycle, no partial resp.
// TESTING
//  READ16 {0005,0003,0000,0042}, reg_ack+rdata=BEEF after 2 cycles, id=0005
//   -> reg_request 1 cycle after w3; resp {0003,0005,2000,BEEF}, last on w3.
//  WRITE16 {..,0400,0010,1234} -> reg_write=1 addr=0010 wdata=1234;
//   resp 3 words, flags 2800.
//  READ16 with 5 words -> no reg_request; resp flags 2400, 3 words.
//  ACCESS_TIMEOUT=8, no ack -> reg_request high exactly 8 cycles; resp flags 2400.
//  type=01 packet, then in_first mid-packet, then out_ready low 10 cycles
//   -> first dropped, abort works, resp intact.
//  rst during TX_SRC -> out_valid 0 next cycle; next request answered normally.

Source files
------------

// File: rtl/osd_regaccess_responder.sv
// Debug-ring endpoint answering register-access request packets: receive one
// request, run one access on the local register bus, send back the response.
//
// state    | meaning
// RX_DEST  | idle, waiting for a first word (w0, destination)
// RX_SRC   | waiting for w1, requester address
// RX_FLAGS | waiting for w2, type/subtype
// RX_ADDR  | waiting for w3, register address
// RX_DATA  | waiting for w4, write data
// RX_DRAIN | discarding words up to in_last (silent or error pending)
// ACCESS   | reg_request held until ack, err or timeout
// TX_DEST  | sending response word 0 (requester address)
// TX_SRC   | sending response word 1 (own id)
// TX_FLAGS | sending response flags
// TX_DATA  | sending read data (READ_OK only)
module osd_regaccess_responder #(
  parameter int unsigned ACCESS_TIMEOUT = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] id_i,
  input  logic [15:0] in_data_i,
  input  logic        in_valid_i,
  input  logic        in_first_i,
  input  logic        in_last_i,
  output logic        in_ready_o,
  output logic [15:0] out_data_o,
  output logic        out_valid_o,
  output logic        out_first_o,
  output logic        out_last_o,
  input  logic        out_ready_i,
  output logic        reg_request_o,
  output logic        reg_write_o,
  output logic [15:0] reg_addr_o,
  output logic [15:0] reg_wdata_o,
  input  logic        reg_ack_i,
  input  logic        reg_err_i,
  input  logic [15:0] reg_rdata_i
);

  typedef enum logic [3:0] {
    RX_DEST, RX_SRC, RX_FLAGS, RX_ADDR, RX_DATA, RX_DRAIN,
    ACCESS, TX_DEST, TX_SRC, TX_FLAGS, TX_DATA
  } state_e;

  localparam logic [15:0] FLAGS_READ_OK   = 16'h2000;
  localparam logic [15:0] FLAGS_READ_ERR  = 16'h2400;
  localparam logic [15:0] FLAGS_WRITE_OK  = 16'h2800;
  localparam logic [15:0] FLAGS_WRITE_ERR = 16'h2C00;

  state_e      state_q, state_d;
  logic [15:0] dest_q, dest_d, addr_q, addr_d, wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d, flags_q, flags_d, out_data_q, out_data_d;
  logic [3:0]  subtype_q, subtype_d;
  logic        write_q, write_d, err_pend_q, err_pend_d, send_data_q, send_data_d;
  logic [31:0] tmo_q, tmo_d;
  logic        in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic        out_first_q, out_first_d, out_last_q, out_last_d;
  logic        reg_request_q, reg_request_d;
  logic        rx_acc, tx_hs, timeout, bus_fail, bus_done;

  always_comb begin
    rx_acc   = in_valid_i & in_ready_q;
    tx_hs    = out_valid_q & out_ready_i;
    timeout  = (ACCESS_TIMEOUT != 0) && (tmo_q == ACCESS_TIMEOUT - 1);
    bus_fail = reg_err_i | timeout;
    bus_done = reg_ack_i | bus_fail;

    state_d     = state_q;
    dest_d      = dest_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    flags_d     = flags_q;
    subtype_d   = subtype_q;
    write_d     = write_q;
    err_pend_d  = err_pend_q;
    send_data_d = send_data_q;
    tmo_d       = '0;

    // A first word in any receive state restarts packet reception.
    if (rx_acc && in_first_i) begin
      err_pend_d = 1'b0;
      state_d    = in_last_i ? RX_DEST : RX_SRC;
    end else begin
      case (state_q)
        RX_DEST: ;
        RX_SRC: if (rx_acc) begin
          dest_d  = in_data_i;
          state_d = in_last_i ? RX_DEST : RX_FLAGS;
        end
        RX_FLAGS: if (rx_acc) begin
          subtype_d  = in_data_i[13:10];
          err_pend_d = 1'b0;
          if (in_last_i)                    state_d = RX_DEST;
          else if (in_data_i[15:14] != 2'b00) state_d = RX_DRAIN;
          else                              state_d = RX_ADDR;
        end
        RX_ADDR: if (rx_acc) begin
          addr_d      = in_data_i;
          send_data_d = 1'b0;
          write_d     = (subtype_q == 4'b0001);
          if (subtype_q == 4'b0000 && in_last_i) begin
            state_d = ACCESS;
          end else if (subtype_q == 4'b0001 && !in_last_i) begin
            state_d = RX_DATA;
          end else begin
            flags_d    = (subtype_q == 4'b0001) ? FLAGS_WRITE_ERR : FLAGS_READ_ERR;
            err_pend_d = 1'b1;
            state_d    = in_last_i ? TX_DEST : RX_DRAIN;
          end
        end
        RX_DATA: if (rx_acc) begin
          wdata_d = in_data_i;
          if (in_last_i) begin
            state_d = ACCESS;
          end else begin
            flags_d    = FLAGS_WRITE_ERR;
            err_pend_d = 1'b1;
            state_d    = RX_DRAIN;
          end
        end
        RX_DRAIN: if (rx_acc && in_last_i) state_d = err_pend_q ? TX_DEST : RX_DEST;
        ACCESS: begin
          tmo_d = tmo_q + 32'd1;
          if (bus_done) begin
            tmo_d       = '0;
            rdata_d     = reg_rdata_i;
            send_data_d = !write_q && !bus_fail;
            if (write_q) flags_d = bus_fail ? FLAGS_WRITE_ERR : FLAGS_WRITE_OK;
            else         flags_d = bus_fail ? FLAGS_READ_ERR  : FLAGS_READ_OK;
            state_d = TX_DEST;
          end
        end
        TX_DEST:  if (tx_hs) state_d = TX_SRC;
        TX_SRC:   if (tx_hs) state_d = TX_FLAGS;
        TX_FLAGS: if (tx_hs) state_d = send_data_q ? TX_DATA : RX_DEST;
        TX_DATA:  if (tx_hs) state_d = RX_DEST;
        default:  state_d = RX_DEST;
      endcase
    end

    // Outputs are registered from the next state so they line up with it.
    in_ready_d    = state_d inside {RX_DEST, RX_SRC, RX_FLAGS, RX_ADDR, RX_DATA, RX_DRAIN};
    out_valid_d   = state_d inside {TX_DEST, TX_SRC, TX_FLAGS, TX_DATA};
    out_first_d   = (state_d == TX_DEST);
    out_last_d    = (state_d == TX_DATA) || (state_d == TX_FLAGS && !send_data_d);
    reg_request_d = (state_d == ACCESS);
    case (state_d)
      TX_DEST:  out_data_d = dest_d;
      TX_SRC:   out_data_d = id_i;
      TX_FLAGS: out_data_d = flags_d;
      TX_DATA:  out_data_d = rdata_d;
      default:  out_data_d = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= RX_DEST;
      dest_q        <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      flags_q       <= '0;
      subtype_q     <= '0;
      write_q       <= 1'b0;
      err_pend_q    <= 1'b0;
      send_data_q   <= 1'b0;
      tmo_q         <= '0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_first_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_data_q    <= '0;
      reg_request_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      dest_q        <= dest_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      flags_q       <= flags_d;
      subtype_q     <= subtype_d;
      write_q       <= write_d;
      err_pend_q    <= err_pend_d;
      send_data_q   <= send_data_d;
      tmo_q         <= tmo_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_first_q   <= out_first_d;
      out_last_q    <= out_last_d;
      out_data_q    <= out_data_d;
      reg_request_q <= reg_request_d;
    end
  end

  assign in_ready_o    = in_ready_q;
  assign out_valid_o   = out_valid_q;
  assign out_first_o   = out_first_q;
  assign out_last_o    = out_last_q;
  assign out_data_o    = out_data_q;
  assign reg_request_o = reg_request_q;
  assign reg_write_o   = write_q;
  assign reg_addr_o    = addr_q;
  assign reg_wdata_o   = wdata_q;

endmodule

// File: tb/tb_osd_regaccess_responder.sv
// Scoreboard bench for osd_regaccess_responder: a packet-level reference model
// predicts bus accesses and response words; monitors compare as the DUT acts.
module tb_osd_regaccess_responder;
  localparam logic [15:0] ID  = 16'h0005;
  localparam int          TMO = 8;

  logic clk = 1'b0;
  logic rst;
  logic [15:0] in_data, out_data, reg_addr, reg_wdata, reg_rdata;
  logic in_valid, in_first, in_last, in_ready;
  logic out_valid, out_first, out_last, out_ready;
  logic reg_request, reg_write, reg_ack, reg_err;

  always #5 clk = ~clk;

  osd_regaccess_responder #(.ACCESS_TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .id_i(ID),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_first_i(in_first),
    .in_last_i(in_last), .in_ready_o(in_ready),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_first_o(out_first),
    .out_last_o(out_last), .out_ready_i(out_ready),
    .reg_request_o(reg_request), .reg_write_o(reg_write), .reg_addr_o(reg_addr),
    .reg_wdata_o(reg_wdata), .reg_ack_i(reg_ack), .reg_err_i(reg_err),
    .reg_rdata_i(reg_rdata)
  );

  typedef struct {
    logic [15:0] data;
    logic        first;
    logic        last;
  } word_t;

  typedef struct {
    logic        write;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          delay;
    logic        err;
    logic        both;
    logic        noack;
    logic [15:0] rdata;
  } plan_t;

  word_t exp_q[$];
  word_t stim_q[$];
  word_t pkt[$];
  plan_t plan_q[$];
  bit    active = 0;

  int checks = 0;
  int errors = 0;

  bit          ov_en = 0, ov_err = 0, ov_noack = 0;
  int          ov_delay = 0;
  logic [15:0] ov_rdata = '0;
  bit          ready_manual = 1, ready_val = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_exp(input logic [15:0] d, input logic f, input logic l);
    word_t w;
    w.data = d; w.first = f; w.last = l;
    exp_q.push_back(w);
  endfunction

  function automatic void push_resp(input logic [15:0] dst, input logic [15:0] flags,
                                    input bit has_data, input logic [15:0] rd);
    push_exp(dst, 1'b1, 1'b0);
    push_exp(ID, 1'b0, 1'b0);
    push_exp(flags, 1'b0, !has_data);
    if (has_data) push_exp(rd, 1'b0, 1'b1);
  endfunction

  // Packet-level model: decide outcome of a complete accepted packet.
  function automatic void evaluate();
    int          n = pkt.size();
    logic [15:0] fl, src;
    plan_t       p;
    bit          failed;
    if (n < 4) return;
    fl  = pkt[2].data;
    src = pkt[1].data;
    if (fl[15:14] != 2'b00) return;
    if ((fl[13:10] == 4'd0 && n == 4) || (fl[13:10] == 4'd1 && n == 5)) begin
      p.write = (fl[13:10] == 4'd1);
      p.addr  = pkt[3].data;
      p.wdata = p.write ? pkt[4].data : 16'h0;
      if (ov_en) begin
        p.delay = ov_delay; p.err = ov_err; p.both = 0; p.noack = ov_noack; p.rdata = ov_rdata;
      end else begin
        p.delay = int'($urandom_range(0, 4));
        p.err   = ($urandom_range(0, 3) == 0);
        p.both  = p.err && ($urandom_range(0, 1) == 1);
        p.noack = 0;
        p.rdata = 16'($urandom);
      end
      failed = p.err || p.noack;
      plan_q.push_back(p);
      if (p.write) push_resp(src, failed ? 16'h2C00 : 16'h2800, 0, 16'h0);
      else         push_resp(src, failed ? 16'h2400 : 16'h2000, !failed, p.rdata);
    end else begin
      push_resp(src, (fl[13:10] == 4'd1) ? 16'h2C00 : 16'h2400, 0, 16'h0);
    end
  endfunction

  function automatic void model_word(input word_t w);
    if (w.first) begin
      pkt.delete();
      pkt.push_back(w);
      active = 1;
    end else if (active) begin
      pkt.push_back(w);
    end
    if (w.last && active) begin
      evaluate();
      active = 0;
    end
  endfunction

  // Must be entered between a rising edge and the following falling edge.
  task automatic drive_word(input word_t w);
    bit ok = 0;
    in_data = w.data; in_first = w.first; in_last = w.last; in_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    if (ok) model_word(w);
    else chk("in_ready_wait", 32'd0, 32'd1);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  function automatic void add_word(input logic [15:0] d, input logic f, input logic l);
    word_t w;
    w.data = d; w.first = f; w.last = l;
    stim_q.push_back(w);
  endfunction

  function automatic void add_pkt(input int n, input logic [15:0] a, input logic [15:0] b,
                                  input logic [15:0] c, input logic [15:0] d,
                                  input logic [15:0] e = 16'h0, input logic [15:0] f = 16'h0);
    logic [15:0] w[6];
    w[0] = a; w[1] = b; w[2] = c; w[3] = d; w[4] = e; w[5] = f;
    for (int i = 0; i < n; i++) add_word(w[i], i == 0, i == n - 1);
  endfunction

  task automatic send_stim(input bit gaps);
    while (stim_q.size() > 0) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      drive_word(stim_q.pop_front());
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && plan_q.size() == 0) begin ok = 1; break; end
    end
    chk("drain_wait", 32'(ok), 32'd1);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // Output handshake monitor.
  initial begin
    word_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_word", {16'h0, out_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", {16'h0, out_data}, {16'h0, e.data});
          chk("out_first", 32'(out_first), 32'(e.first));
          chk("out_last", 32'(out_last), 32'(e.last));
        end
      end
    end
  end

  // Register-bus responder and checker.
  initial begin
    plan_t p;
    int    n;
    reg_ack = 0; reg_err = 0; reg_rdata = '0;
    forever begin
      @(negedge clk);
      if (reg_request) begin
        if (plan_q.size() == 0) begin
          chk("unexpected_reg_request", 32'd1, 32'd0);
        end else begin
          p = plan_q.pop_front();
          chk("reg_write", 32'(reg_write), 32'(p.write));
          chk("reg_addr", {16'h0, reg_addr}, {16'h0, p.addr});
          if (p.write) chk("reg_wdata", {16'h0, reg_wdata}, {16'h0, p.wdata});
          if (p.noack) begin
            n = 1;
            while (n < 50) begin
              @(negedge clk);
              if (!reg_request) break;
              n++;
            end
            chk("timeout_request_cycles", 32'(n), 32'(TMO));
          end else begin
            repeat (p.delay) @(negedge clk);
            reg_ack = !p.err || p.both; reg_err = p.err; reg_rdata = p.rdata;
            @(negedge clk);
            reg_ack = 0; reg_err = 0; reg_rdata = 16'($urandom);
            chk("reg_request_drop", 32'(reg_request), 32'd0);
          end
        end
      end
    end
  end

  // out_ready driver: random backpressure unless held manually.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = ready_manual ? ready_val : ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    bit ok;
    int kind;
    logic [15:0] dst, src, addr, wd;
    rst = 1; in_valid = 0; in_first = 0; in_last = 0; in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_reg_request", 32'(reg_request), 32'd0);
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Read, ack after 2 cycles.
    ov_en = 1; ov_delay = 1; ov_err = 0; ov_noack = 0; ov_rdata = 16'hBEEF;
    add_pkt(4, 16'h0005, 16'h0003, 16'h0000, 16'h0042);
    send_stim(0);
    chk("read_req_latency", 32'(reg_request), 32'd1);
    wait_idle();

    // Write.
    add_pkt(5, 16'h0005, 16'h0003, 16'h0400, 16'h0010, 16'h1234);
    send_stim(0);
    wait_idle();

    // Read with 5 words: error, no access.
    add_pkt(5, 16'h0005, 16'h0009, 16'h0000, 16'h0042, 16'h0099);
    send_stim(0);
    wait_idle();

    // Timeout.
    ov_noack = 1;
    add_pkt(4, 16'h0005, 16'h000A, 16'h0000, 16'h0077);
    send_stim(0);
    wait_idle();
    ov_noack = 0;

    // Stray word, foreign type, abort mid-packet, then long backpressure.
    ready_manual = 1; ready_val = 0;
    add_word(16'h1111, 1'b0, 1'b0);
    add_pkt(4, 16'h0005, 16'h0003, 16'h4000, 16'h0042);
    add_word(16'h0005, 1'b1, 1'b0);
    add_word(16'h0004, 1'b0, 1'b0);
    add_word(16'h0000, 1'b0, 1'b0);
    ov_rdata = 16'hCAFE;
    add_pkt(4, 16'h0005, 16'h0007, 16'h0000, 16'h0020);
    send_stim(1);
    repeat (12) begin @(posedge clk); #1; end
    ready_manual = 0;
    wait_idle();

    // Reset while the second response word is pending.
    ready_manual = 1; ready_val = 0;
    ov_delay = 1; ov_rdata = 16'h5A5A;
    add_pkt(4, 16'h0005, 16'h0033, 16'h0000, 16'h0044);
    send_stim(0);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    chk("rst_test_out_valid_wait", 32'(ok), 32'd1);
    ready_val = 1;
    @(negedge clk);
    ready_val = 0;
    @(negedge clk);
    chk("tx_src_pending", 32'(out_valid & !out_first), 32'd1);
    rst = 1;
    @(negedge clk);
    chk("rst_mid_tx_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_tx_out_data", {16'h0, out_data}, 32'd0);
    rst = 0;
    exp_q.delete();
    ready_manual = 0;
    @(posedge clk); #1;
    active = 0;

    ov_rdata = 16'h1357; ov_delay = 0;
    add_pkt(4, 16'h0005, 16'h0021, 16'h0000, 16'h00AB);
    send_stim(0);
    wait_idle();
    ov_en = 0;

    // Randomised traffic.
    for (int k = 0; k < 80; k++) begin
      kind = int'($urandom_range(0, 10));
      dst = 16'($urandom); src = 16'($urandom); addr = 16'($urandom); wd = 16'($urandom);
      case (kind)
        0, 1, 2: add_pkt(4, dst, src, 16'h0000, addr);
        3, 4:    add_pkt(5, dst, src, 16'h0400, addr, wd);
        5:       add_pkt(5, dst, src, 16'h0000, addr, wd);
        6:       if ($urandom_range(0, 1) == 1) add_pkt(4, dst, src, 16'h0400, addr);
                 else add_pkt(6, dst, src, 16'h0400, addr, wd, wd);
        7:       add_pkt(4, dst, src, {2'b00, 4'($urandom_range(2, 15)), 10'h0}, addr);
        8:       add_pkt(5, dst, src, {2'($urandom_range(1, 3)), 14'($urandom)}, addr, wd);
        9: begin
          add_word(wd, 1'b0, ($urandom_range(0, 1) == 1));
          add_pkt(int'($urandom_range(1, 3)), dst, src, 16'h0000, addr);
        end
        default: begin
          add_word(dst, 1'b1, 1'b0);
          add_word(src, 1'b0, 1'b0);
          if ($urandom_range(0, 1) == 1) add_word(16'h0400, 1'b0, 1'b0);
          add_pkt(4, dst, wd, 16'h0000, addr);
        end
      endcase
      send_stim(1);
    end
    wait_idle();
    chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("plan_queue_empty", 32'(plan_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
